// File: rtl/vga_frame_checker.sv
// Purpose: locks to v_sync, builds a per-frame pixel signature, counts visible geometry, flags errors.
// Latency: frame_done/published outputs update one clk after the frame-edge pix_en cycle.
// Backpressure: none; pix_en qualifies every sample. Define VGA_FRAME_CHECKER_ROTXOR_EN for a rotate-xor signature.
module vga_frame_checker #(
   parameter int H_VISIBLE       = 640,
   parameter int V_VISIBLE       = 480,
   parameter int COLOR_W         = 8,
   parameter int SIG_W           = 32,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   input  logic               visible,
   input  logic               h_sync,
   input  logic               v_sync,
   input  logic [COLOR_W-1:0] red,
   input  logic [COLOR_W-1:0] green,
   input  logic [COLOR_W-1:0] blue,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [SIG_W-1:0]   signature,
   output logic [15:0]        last_lines,
   output logic               locked,
   output logic               h_err,
   output logic               v_err,
   output logic               sync_err
);

   typedef enum logic {SEEK, CAPTURE} state_t;

   state_t             state_q, state_d;
   logic               prev_vis, prev_vs;
   logic [SIG_W-1:0]   sig_q, sig_next, sig_upd, pix_word;
   logic [15:0]        pix_cnt, pix_upd, line_cnt, line_upd;
   logic               hs_act, vs_act, frame_edge, line_end, h_short;
   logic               start, publish;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign hs_act     = SYNC_ACTIVE_LOW ? ~h_sync : h_sync;
   assign vs_act     = SYNC_ACTIVE_LOW ? ~v_sync : v_sync;
   assign frame_edge = pix_en & vs_act & ~prev_vs;
   assign line_end   = pix_en & ~visible & prev_vis;
   assign pix_word   = SIG_W'({red, green, blue});

`ifdef VGA_FRAME_CHECKER_ROTXOR_EN
   assign sig_next = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ pix_word;
`else
   assign sig_next = sig_q + pix_word;
`endif

   // Same-cycle view of the accumulators, so a frame edge publishes the pixel/line sampled with it.
   assign sig_upd  = visible ? sig_next : sig_q;
   assign pix_upd  = line_end ? 16'd0 : (visible ? sat_inc(pix_cnt) : pix_cnt);
   assign line_upd = line_end ? sat_inc(line_cnt) : line_cnt;
   assign h_short  = line_end && (pix_cnt != 16'(H_VISIBLE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SEEK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      publish = 1'b0;
      case (state_q)
         SEEK: begin
            if (frame_edge) begin
               state_d = CAPTURE;
               start   = 1'b1;
            end
         end
         CAPTURE: begin
            if (frame_edge) begin
               publish = 1'b1;
            end
         end
         default: state_d = SEEK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_vis    <= 1'b0;
         prev_vs     <= 1'b0;
         sig_q       <= '0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         signature   <= '0;
         last_lines  <= '0;
         locked      <= 1'b0;
         h_err       <= 1'b0;
         v_err       <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_done <= publish;
         if (pix_en) begin
            prev_vis <= visible;
            prev_vs  <= vs_act;
            if (visible && (hs_act || vs_act)) begin
               sync_err <= 1'b1;
            end
         end
         if (start) begin
            sig_q    <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            locked   <= 1'b1;
         end else if (state_q == CAPTURE && pix_en) begin
            if (h_short) begin
               h_err <= 1'b1;
            end
            if (publish) begin
               signature   <= sig_upd;
               last_lines  <= line_upd;
               frame_count <= frame_count + 16'd1;
               if (line_upd != 16'(V_VISIBLE)) begin
                  v_err <= 1'b1;
               end
               sig_q    <= '0;
               pix_cnt  <= '0;
               line_cnt <= '0;
            end else begin
               sig_q    <= sig_upd;
               pix_cnt  <= pix_upd;
               line_cnt <= line_upd;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker: directed table, hand sequences and random traffic against a frame-level model.
module tb_vga_frame_checker;
   localparam int H = 4;
   localparam int V = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en, visible, h_sync, v_sync;
   logic [7:0]  red, green, blue;
   logic        frame_done, locked, h_err, v_err, sync_err;
   logic [15:0] frame_count, last_lines;
   logic [31:0] signature;

   vga_frame_checker #(
      .H_VISIBLE(H), .V_VISIBLE(V), .COLOR_W(8), .SIG_W(32), .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .visible(visible),
      .h_sync(h_sync), .v_sync(v_sync), .red(red), .green(green), .blue(blue),
      .frame_done(frame_done), .frame_count(frame_count), .signature(signature),
      .last_lines(last_lines), .locked(locked), .h_err(h_err), .v_err(v_err),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Frame-level model: keeps the captured pixels and line lengths of the open frame.
   logic [23:0] fpix[$];
   int          nlines, cur_len;
   bit          m_cap, pvis, pvs;
   logic [31:0] e_sig;
   logic [15:0] e_lines, e_fc;
   bit          e_fd, e_lock, e_h, e_v, e_s;

   function automatic logic [31:0] fold();
      logic [31:0] s = 32'd0;
      foreach (fpix[i]) begin
`ifdef VGA_FRAME_CHECKER_ROTXOR_EN
         s = {s[30:0], s[31]} ^ {8'h00, fpix[i]};
`else
         s = s + {8'h00, fpix[i]};
`endif
      end
      return s;
   endfunction

   task automatic m_reset();
      fpix.delete();
      nlines = 0; cur_len = 0; m_cap = 0; pvis = 0; pvs = 0;
      e_sig = 0; e_lines = 0; e_fc = 0;
      e_fd = 0; e_lock = 0; e_h = 0; e_v = 0; e_s = 0;
   endtask

   task automatic m_step(input bit en, input bit vis, input bit hs_a, input bit vs_a,
                         input logic [23:0] rgb);
      bit fe, lend;
      e_fd = 0;
      if (!en) return;
      fe   = vs_a && !pvs;
      lend = !vis && pvis;
      if (vis && (hs_a || vs_a)) e_s = 1;
      if (m_cap) begin
         if (vis) begin
            fpix.push_back(rgb);
            cur_len++;
         end
         if (lend) begin
            if (cur_len != H) e_h = 1;
            nlines++;
            cur_len = 0;
         end
         if (fe) begin
            e_sig   = fold();
            e_lines = 16'(nlines);
            if (nlines != V) e_v = 1;
            e_fc = e_fc + 16'd1;
            e_fd = 1;
            fpix.delete();
            nlines = 0; cur_len = 0;
         end
      end else if (fe) begin
         m_cap = 1; e_lock = 1;
         fpix.delete();
         nlines = 0; cur_len = 0;
      end
      pvis = vis;
      pvs  = vs_a;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " frame_done"}, 32'(frame_done), 32'(e_fd));
      chk({tag, " frame_count"}, 32'(frame_count), 32'(e_fc));
      chk({tag, " signature"}, signature, e_sig);
      chk({tag, " last_lines"}, 32'(last_lines), 32'(e_lines));
      chk({tag, " locked"}, 32'(locked), 32'(e_lock));
      chk({tag, " h_err"}, 32'(h_err), 32'(e_h));
      chk({tag, " v_err"}, 32'(v_err), 32'(e_v));
      chk({tag, " sync_err"}, 32'(sync_err), 32'(e_s));
   endtask

   // Sync arguments are in asserted form; pins are active-low.
   task automatic cyc(input bit en, input bit vis, input bit hs_a, input bit vs_a,
                      input logic [23:0] rgb, input string tag);
      pix_en = en; visible = vis; h_sync = ~hs_a; v_sync = ~vs_a;
      {red, green, blue} = rgb;
      @(posedge clk);
      m_step(en, vis, hs_a, vs_a, rgb);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic vpulse(input string tag);
      cyc(1, 0, 0, 1, 24'h0, tag);
      cyc(1, 0, 0, 0, 24'h0, tag);
   endtask

   task automatic line(input int n, input logic [23:0] rgb, input string tag);
      for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, rgb, tag);
      cyc(1, 0, 1, 0, 24'h0, tag);
   endtask

   task automatic do_reset(input string tag);
      pix_en = 0; visible = 0; h_sync = 1; v_sync = 1;
      red = 0; green = 0; blue = 0;
      reset = 1;
      m_reset();
      #1;
      chk({tag, " rst frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, " rst frame_count"}, 32'(frame_count), 32'd0);
      chk({tag, " rst signature"}, signature, 32'd0);
      chk({tag, " rst last_lines"}, 32'(last_lines), 32'd0);
      chk({tag, " rst locked"}, 32'(locked), 32'd0);
      chk({tag, " rst errors"}, {29'd0, h_err, v_err, sync_err}, 32'd0);
      @(negedge clk);
      reset = 0;
   endtask

   typedef struct {
      bit          en, vis, hs, vs;
      logic [23:0] rgb;
      bit          exp_fd, exp_locked;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit en, input bit vis, input bit hs, input bit vs,
                               input logic [23:0] rgb, input bit fd, input bit lk);
      vec_t v;
      v.en = en; v.vis = vis; v.hs = hs; v.vs = vs; v.rgb = rgb;
      v.exp_fd = fd; v.exp_locked = lk;
      return v;
   endfunction

`ifdef VGA_FRAME_CHECKER_ROTXOR_EN
   localparam logic [31:0] SIG12 = 32'h0000_0FFF;
   localparam logic [31:0] SIG2  = 32'd3;
`else
   localparam logic [31:0] SIG12 = 32'd12;
   localparam logic [31:0] SIG2  = 32'd2;
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bit seen_fd;

      // Clean frame: 3 lines x 4 pixels of 0x000001 framed by two v_sync pulses.
      tbl.push_back(mk(1, 0, 0, 1, 24'h0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 24'h0, 0, 1));
      for (int l = 0; l < V; l++) begin
         for (int p = 0; p < H; p++) tbl.push_back(mk(1, 1, 0, 0, 24'h1, 0, 1));
         tbl.push_back(mk(1, 0, 1, 0, 24'h0, 0, 1));
      end
      tbl.push_back(mk(1, 0, 0, 1, 24'h0, 1, 1));
      tbl.push_back(mk(1, 0, 0, 0, 24'h0, 0, 1));

      @(negedge clk);
      do_reset("init");

      // Pixels before lock must not leak into the signature.
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 24'hFFFFFF, "prelock");
      cyc(1, 0, 0, 0, 24'h0, "prelock");
      chk("prelock locked", 32'(locked), 32'd0);

      foreach (tbl[i]) begin
         cyc(tbl[i].en, tbl[i].vis, tbl[i].hs, tbl[i].vs, tbl[i].rgb, "tbl");
         chk($sformatf("tbl[%0d] frame_done", i), 32'(frame_done), 32'(tbl[i].exp_fd));
         chk($sformatf("tbl[%0d] locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      end
      chk("clean signature", signature, SIG12);
      chk("clean last_lines", 32'(last_lines), 32'd3);
      chk("clean frame_count", 32'(frame_count), 32'd1);
      chk("clean errors", {29'd0, h_err, v_err, sync_err}, 32'd0);

      // Short line: h_err sticks, line count still correct.
      line(4, 24'h1, "short"); line(3, 24'h1, "short"); line(4, 24'h1, "short");
      vpulse("short");
      chk("short h_err", 32'(h_err), 32'd1);
      chk("short v_err", 32'(v_err), 32'd0);
      chk("short last_lines", 32'(last_lines), 32'd3);
      for (int l = 0; l < V; l++) line(4, 24'h000102, "after");
      vpulse("after");
      chk("after h_err sticky", 32'(h_err), 32'd1);
      chk("after frame_count", 32'(frame_count), 32'd3);
      chk("after signature", signature, 32'd12 * 32'h000102);

      // Two-pixel frame.
      do_reset("two");
      vpulse("two");
      cyc(1, 1, 0, 0, 24'h1, "two");
      cyc(1, 1, 0, 0, 24'h1, "two");
      cyc(1, 0, 0, 0, 24'h0, "two");
      vpulse("two");
      chk("two signature", signature, SIG2);
      chk("two v_err", 32'(v_err), 32'd1);
      chk("two last_lines", 32'(last_lines), 32'd1);

      // v_sync toggling without pix_en is invisible.
      do_reset("noen");
      seen_fd = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, bit'(i % 2), 24'h0, "noen");
         if (frame_done) seen_fd = 1;
      end
      chk("noen frame_done seen", 32'(seen_fd), 32'd0);
      chk("noen locked", 32'(locked), 32'd0);

      // Reset mid-frame: two further v_sync assertions needed for a publish.
      do_reset("mid");
      vpulse("mid");
      line(4, 24'h7, "mid");
      do_reset("mid2");
      vpulse("mid2");
      chk("mid2 locked", 32'(locked), 32'd1);
      chk("mid2 frame_count", 32'(frame_count), 32'd0);
      for (int l = 0; l < V; l++) line(4, 24'h1, "mid2");
      cyc(1, 0, 0, 1, 24'h0, "mid2");
      chk("mid2 frame_done", 32'(frame_done), 32'd1);
      chk("mid2 frame_count", 32'(frame_count), 32'd1);

      // Visible pixel during sync.
      cyc(1, 1, 1, 0, 24'h5, "syncerr");
      chk("syncerr sync_err", 32'(sync_err), 32'd1);

      // Random traffic against the model.
      do_reset("rnd");
      for (int i = 0; i < 4000; i++) begin
         if (i % 700 == 350) begin
            vpulse("rnd");
            for (int l = 0; l < V; l++) line(H, 24'($urandom), "rnd");
            vpulse("rnd");
         end else begin
            cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) != 0),
                bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 29) == 0),
                24'($urandom), "rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
